mesi_snoop: RTL
===============

Name: mesi_snoop

Overview:
- Bus-side (snooping) end of the MESI coherence protocol. Consumes the 2-bit bus messages a peer MESI controller emits and applies them to a local per-line state table.
- Issues memory write-back messages on the memory channel when a Modified line is snooped.
- Reports the resulting 2-bit MESI state using the same encoding the seven-segment state display uses.
- Sits between the shared bus and the local cache controller, which installs lines through a side port.

Parameters:
- LINES, 4, number of direct-mapped lines in the state table.
- IDX_W, 2, line index width (log2 LINES).
- TAG_W, 4, tag width stored per line.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- bus_valid  in  1  bus message present.
- bus_msg  in  2  00 none, 01 read-miss, 10 write-miss, 11 invalidate.
- bus_idx  in  IDX_W  line index of bus address.
- bus_tag  in  TAG_W  tag of bus address.
- bus_ready  out  1  snooper can accept a message.
- mem_req  out  1  memory write-back request.
- mem_msg  out  2  00 none, 01 write-back.
- mem_idx  out  IDX_W  line being written back.
- mem_tag  out  TAG_W  tag being written back.
- mem_ack  in  1  memory accepted write-back.
- snoop_done  out  1  one-cycle pulse: snoop finished.
- snoop_hit  out  1  valid with done: line present (state != I, tag match).
- snoop_state  out  2  valid with done: line state after snoop.
- snoop_err  out  1  valid with done: invalidate hit an E or M line.
- loc_we  in  1  local install/update strobe.
- loc_idx  in  IDX_W  local line index.
- loc_tag  in  TAG_W  local tag.
- loc_state  in  2  local new state.
- loc_ready  out  1  local write will be applied this cycle.

Behaviour:
- State encoding: 00 I, 01 S, 10 E, 11 M.
- Reset (async, reset_n=0): every line state=I and tag=0. FSM goes to IDLE. mem_req, mem_msg, mem_idx, mem_tag, snoop_* all 0. mem_req drops immediately, even mid write-back. bus_ready=loc_ready=1 once reset deasserts.
- FSM states: IDLE, LOOKUP, WB, RESP. bus_ready = loc_ready = (FSM==IDLE), combinational.
- IDLE:
  - bus_valid=1 with bus_msg!=00: capture msg/idx/tag, go to LOOKUP.
  - bus_msg=00: ignored, stay in IDLE.
- LOOKUP (1 cycle): compute hit from the registered table.
  - hit with state M and msg read-miss or write-miss: go to WB.
  - All other cases: go to RESP.
- WB:
  - mem_req=1, mem_msg=01, mem_idx/mem_tag = captured values. Held stable until mem_ack=1.
  - On the ack edge: go to RESP. mem_req and mem_msg return to 0 the next cycle.
  - No timeout.
- RESP (1 cycle): snoop_done=1 plus hit/state/err; table entry updated at this edge; then IDLE.
- Next state:
  - read-miss: M→S (after WB), E→S, S→S.
  - write-miss: M→I (after WB), E/S→I.
  - invalidate: S→I; E/M→I with snoop_err=1 and no write-back.
  - Miss (I, or tag mismatch): entry unchanged; snoop_state = stored state of that index if tags match, else 00.
- Latency from accept edge to done: 2 cycles without WB; (ack edge + 1) with WB. Zero wait on mem_ack gives 3 cycles.
- Local port: loc_we is applied at the edge only when loc_ready=1 (writes state and tag). Outside IDLE it is dropped silently.
- Simultaneous loc_we and bus accept in IDLE: both take effect. LOOKUP sees the locally written entry.
- Back-to-back messages: bus_ready is 0 from LOOKUP through RESP. The next message is accepted on the cycle after RESP at the earliest.

Optional Feature:
- Macro: MESI_SNOOP_HITCNT_EN.
- Defined: adds output hit_count[7:0], reset 0. It increments on every RESP with snoop_hit=1 and saturates at 255.
- Undefined: no hit_count port or counter logic; all other behaviour identical.

Test Plan:
- Reset, then read-miss idx=1 tag=3 → snoop_done 2 cycles after accept, hit=0, state=00, mem_req never asserted.
- loc_we idx=2 tag=5 state=E, then read-miss idx=2 tag=5 → hit=1, state=01, table[2]=S.
- Line M (idx=0 tag=7), write-miss → mem_req=1 with idx=0 tag=7 msg=01 until mem_ack (held off 4 cycles); done one cycle after ack, state=00.
- Line E, invalidate → snoop_err=1, state=00, no mem_req. Repeat with line S → snoop_err=0, state=00.
- loc_we during LOOKUP/WB (loc_ready=0) → table unchanged. Simultaneous loc_we and bus_valid in IDLE on the same idx → lookup uses the new value.
- reset_n low while in WB → mem_req=0 immediately; after release all lines I and bus_ready=1. With MESI_SNOOP_HITCNT_EN, 300 hits → hit_count=255.

Source files
------------

// File: rtl/mesi_snoop.sv
// Snooping side of a MESI coherence controller: applies peer bus messages to a
// per-line state table. Optional MESI_SNOOP_HITCNT_EN adds a saturating hit counter.
module mesi_snoop #(
    parameter int unsigned LINES = 4,
    parameter int unsigned IDX_W = 2,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             bus_valid,
    input  logic [1:0]       bus_msg,
    input  logic [IDX_W-1:0] bus_idx,
    input  logic [TAG_W-1:0] bus_tag,
    output logic             bus_ready,
    output logic             mem_req,
    output logic [1:0]       mem_msg,
    output logic [IDX_W-1:0] mem_idx,
    output logic [TAG_W-1:0] mem_tag,
    input  logic             mem_ack,
    output logic             snoop_done,
    output logic             snoop_hit,
    output logic [1:0]       snoop_state,
    output logic             snoop_err,
`ifdef MESI_SNOOP_HITCNT_EN
    output logic [7:0]       hit_count,
`endif
    input  logic             loc_we,
    input  logic [IDX_W-1:0] loc_idx,
    input  logic [TAG_W-1:0] loc_tag,
    input  logic [1:0]       loc_state,
    output logic             loc_ready
);

    typedef enum logic [1:0] {MESI_I = 2'b00, MESI_S = 2'b01, MESI_E = 2'b10, MESI_M = 2'b11} mesi_t;
    typedef enum logic [1:0] {MSG_NONE = 2'b00, MSG_RD = 2'b01, MSG_WR = 2'b10, MSG_INV = 2'b11} msg_t;
    typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_WB, ST_RESP} fsm_t;

    fsm_t             fsm_q;
    mesi_t            st_q  [LINES];
    logic [TAG_W-1:0] tag_q [LINES];
    msg_t             cap_msg_q;
    logic [IDX_W-1:0] cap_idx_q;
    logic [TAG_W-1:0] cap_tag_q;

    logic             mem_req_q;
    logic [1:0]       mem_msg_q;
    logic [IDX_W-1:0] mem_idx_q;
    logic [TAG_W-1:0] mem_tag_q;
    logic             snoop_done_q;
    logic             snoop_hit_q;
    mesi_t            snoop_state_q;
    logic             snoop_err_q;
`ifdef MESI_SNOOP_HITCNT_EN
    logic [7:0]       hit_cnt_q;
    assign hit_count = hit_cnt_q;
`endif

    mesi_t cur_st;
    logic  tag_eq;
    logic  lk_hit_d;
    logic  lk_wb_d;
    logic  lk_err_d;
    mesi_t lk_state_d;

    assign cur_st = st_q[cap_idx_q];
    assign tag_eq = (tag_q[cap_idx_q] == cap_tag_q);

    always_comb begin
        lk_hit_d   = tag_eq && (cur_st != MESI_I);
        lk_wb_d    = 1'b0;
        lk_err_d   = 1'b0;
        lk_state_d = tag_eq ? cur_st : MESI_I;
        if (lk_hit_d) begin
            case (cap_msg_q)
                MSG_RD: begin
                    lk_state_d = MESI_S;
                    lk_wb_d    = (cur_st == MESI_M);
                end
                MSG_WR: begin
                    lk_state_d = MESI_I;
                    lk_wb_d    = (cur_st == MESI_M);
                end
                MSG_INV: begin
                    lk_state_d = MESI_I;
                    lk_err_d   = (cur_st == MESI_E) || (cur_st == MESI_M);
                end
                default: ;
            endcase
        end
    end

    assign bus_ready   = (fsm_q == ST_IDLE);
    assign loc_ready   = (fsm_q == ST_IDLE);
    assign mem_req     = mem_req_q;
    assign mem_msg     = mem_msg_q;
    assign mem_idx     = mem_idx_q;
    assign mem_tag     = mem_tag_q;
    assign snoop_done  = snoop_done_q;
    assign snoop_hit   = snoop_hit_q;
    assign snoop_state = snoop_state_q;
    assign snoop_err   = snoop_err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q         <= ST_IDLE;
            cap_msg_q     <= MSG_NONE;
            cap_idx_q     <= '0;
            cap_tag_q     <= '0;
            mem_req_q     <= 1'b0;
            mem_msg_q     <= '0;
            mem_idx_q     <= '0;
            mem_tag_q     <= '0;
            snoop_done_q  <= 1'b0;
            snoop_hit_q   <= 1'b0;
            snoop_state_q <= MESI_I;
            snoop_err_q   <= 1'b0;
            for (int unsigned i = 0; i < LINES; i++) begin
                st_q[i]  <= MESI_I;
                tag_q[i] <= '0;
            end
`ifdef MESI_SNOOP_HITCNT_EN
            hit_cnt_q     <= '0;
`endif
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (loc_we) begin
                        st_q[loc_idx]  <= mesi_t'(loc_state);
                        tag_q[loc_idx] <= loc_tag;
                    end
                    if (bus_valid && (bus_msg != MSG_NONE)) begin
                        cap_msg_q <= msg_t'(bus_msg);
                        cap_idx_q <= bus_idx;
                        cap_tag_q <= bus_tag;
                        fsm_q     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    // Result is latched now; on a write-back it waits until the ack edge to be flagged done.
                    snoop_hit_q   <= lk_hit_d;
                    snoop_state_q <= lk_state_d;
                    snoop_err_q   <= lk_err_d;
                    if (lk_wb_d) begin
                        mem_req_q <= 1'b1;
                        mem_msg_q <= 2'b01;
                        mem_idx_q <= cap_idx_q;
                        mem_tag_q <= cap_tag_q;
                        fsm_q     <= ST_WB;
                    end else begin
                        snoop_done_q <= 1'b1;
                        fsm_q        <= ST_RESP;
                    end
                end
                ST_WB: begin
                    if (mem_ack) begin
                        mem_req_q    <= 1'b0;
                        mem_msg_q    <= '0;
                        snoop_done_q <= 1'b1;
                        fsm_q        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    snoop_done_q <= 1'b0;
                    if (snoop_hit_q) begin
                        st_q[cap_idx_q] <= snoop_state_q;
                    end
`ifdef MESI_SNOOP_HITCNT_EN
                    if (snoop_hit_q && (hit_cnt_q != 8'hFF)) begin
                        hit_cnt_q <= hit_cnt_q + 8'd1;
                    end
`endif
                    fsm_q <= ST_IDLE;
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

endmodule
